// File: rtl/spi_aes_pkg.sv
// Shared constants for the SPI-facing AES register bank.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: register address map, STATUS and CTRL bit positions, control FSM
// state encoding.
package spi_aes_pkg;

  // Register map. KEY/DATA/RESULT are 16-byte windows selected by addr[5:4];
  // the low nibble is the byte index, byte 0 being the MSB of the block.
  localparam logic [5:0] KEY_BASE  = 6'h00;
  localparam logic [5:0] DATA_BASE = 6'h10;
  localparam logic [5:0] RES_BASE  = 6'h20;
  localparam logic [5:0] CTRL_ADDR = 6'h30;
  localparam logic [5:0] STAT_ADDR = 6'h31;

  // STATUS byte bit positions; bits 7:5 read as zero.
  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_ERR   = 2;
  localparam int ST_KFULL = 3;
  localparam int ST_DFULL = 4;

  // CTRL byte bit positions.
  localparam int CTRL_START = 0;
  localparam int CTRL_CLR   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

endpackage

// File: rtl/spi_aes_regbank_byte_reg128.sv
// 16-byte register with byte write, per-byte written mask, clear and read mux.
// Latency: write lands on the next edge; read mux is combinational.
// Backpressure: none; every write strobe is accepted in the cycle it appears.
//
// Ports: clk/rstb clock and async active-low reset; wr_en/wr_idx/wr_dat byte
// write; clr zeroes contents and mask; mask_clr zeroes only the mask;
// rd_idx/rd_dat byte read; q whole block; mask/full load tracking.
module byte_reg128
  import spi_aes_pkg::*;
#(
  parameter int REG_W = 8,
  parameter int BLK_W = 128
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      wr_en,
  input  logic [3:0]                wr_idx,
  input  logic [REG_W-1:0]          wr_dat,
  input  logic                      clr,
  input  logic                      mask_clr,
  input  logic [3:0]                rd_idx,
  output logic [REG_W-1:0]          rd_dat,
  output logic [BLK_W-1:0]          q,
  output logic [BLK_W/REG_W-1:0]    mask,
  output logic                      full
);

  localparam int NBYTES = BLK_W / REG_W;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      q    <= '0;
      mask <= '0;
    end else if (clr) begin
      q    <= '0;
      mask <= '0;
    end else begin
      if (mask_clr) begin
        mask <= '0;
      end
      // Byte 0 sits at the top of the block.
      if (wr_en) begin
        q[(NBYTES-1-int'(wr_idx))*REG_W +: REG_W] <= wr_dat;
        mask[wr_idx]                              <= 1'b1;
      end
    end
  end

  assign rd_dat = q[(NBYTES-1-int'(rd_idx))*REG_W +: REG_W];
  assign full   = &mask;

endmodule

// File: rtl/spi_aes_regbank.sv
// Byte-wide register bank between the SPI front end and an AES-128 core.
// Latency: writes take effect next edge; reads are combinational; STATUS lags
//   the internal state by one register stage.
// Backpressure: none; the front end never stalls, illegal accesses set ERR.
//
// Ports: clk, rstb (async active-low), ena (global hold);
//   reg_addr/reg_rw/reg_data_o/reg_data_o_dv/reg_addr_v from the SPI front end,
//   reg_data_i read data back to it, status registered status byte;
//   aes_key/aes_data/aes_start to the core, aes_done/aes_result from it.
module spi_aes_regbank
  import spi_aes_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int REG_W  = 8,
  parameter int BLK_W  = 128
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic              reg_rw,
  input  logic [REG_W-1:0]  reg_data_o,
  input  logic              reg_data_o_dv,
  input  logic              reg_addr_v,
  output logic [REG_W-1:0]  reg_data_i,
  output logic [REG_W-1:0]  status,
  output logic [BLK_W-1:0]  aes_key,
  output logic [BLK_W-1:0]  aes_data,
  output logic              aes_start,
  input  logic              aes_done,
  input  logic [BLK_W-1:0]  aes_result
);

  localparam int NBYTES = BLK_W / REG_W;
  localparam int NB_W   = BLK_W / REG_W;

  localparam logic [ADDR_W-1:0] A_KEY  = ADDR_W'(KEY_BASE);
  localparam logic [ADDR_W-1:0] A_DATA = ADDR_W'(DATA_BASE);
  localparam logic [ADDR_W-1:0] A_RES  = ADDR_W'(RES_BASE);
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(CTRL_ADDR);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(STAT_ADDR);

  fsm_t state_q, state_d;
  logic is_busy, is_done;

  logic [3:0]       byte_idx;
  logic             key_sel, data_sel, res_sel, ctrl_sel, stat_sel;
  logic             wr, ctrl_wr, start_ok, clr_ok, done_ok, stat_clr, err_set;
  logic             err_q;
  logic [BLK_W-1:0] result_q;
  logic [REG_W-1:0] key_rd, data_rd, status_d;
  logic [NB_W-1:0]  key_mask, data_mask;
  logic             key_full, data_full;

  // ---------------------------------------------------------------- decode
  assign byte_idx = reg_addr[3:0];
  assign key_sel  = reg_addr[ADDR_W-1:4] == A_KEY[ADDR_W-1:4];
  assign data_sel = reg_addr[ADDR_W-1:4] == A_DATA[ADDR_W-1:4];
  assign res_sel  = reg_addr[ADDR_W-1:4] == A_RES[ADDR_W-1:4];
  assign ctrl_sel = reg_addr == A_CTRL;
  assign stat_sel = reg_addr == A_STAT;

  // Every event below is qualified by ena so that a low ena freezes all state.
  assign wr       = ena && reg_data_o_dv && reg_rw;
  assign ctrl_wr  = wr && ctrl_sel;
  assign stat_clr = ena && reg_addr_v && !reg_rw && stat_sel;
  assign done_ok  = ena && aes_done && is_busy;

  // CLR takes priority over START when both are written outside BUSY.
  assign clr_ok   = ctrl_wr && reg_data_o[CTRL_CLR] && !is_busy;
  assign start_ok = ctrl_wr && reg_data_o[CTRL_START] && !reg_data_o[CTRL_CLR]
                    && !is_busy && key_full && data_full;

  // A START that neither launches nor is overridden by CLR is an error, as is
  // any CLR or KEY/DATA write attempted while the core is running.
  assign err_set  = (ctrl_wr && reg_data_o[CTRL_START] && !clr_ok && !start_ok)
                 || (ctrl_wr && reg_data_o[CTRL_CLR] && is_busy)
                 || (wr && (key_sel || data_sel) && is_busy);

  // ------------------------------------------------------- KEY / DATA regs
  byte_reg128 #(.REG_W(REG_W), .BLK_W(BLK_W)) u_key (
    .clk      (clk),
    .rstb     (rstb),
    .wr_en    (wr && key_sel && !is_busy),
    .wr_idx   (byte_idx),
    .wr_dat   (reg_data_o),
    .clr      (clr_ok),
    .mask_clr (1'b0),
    .rd_idx   (byte_idx),
    .rd_dat   (key_rd),
    .q        (aes_key),
    .mask     (key_mask),
    .full     (key_full)
  );

  // The data mask is dropped on completion so a new block must be loaded
  // before the next START; the key stays armed.
  byte_reg128 #(.REG_W(REG_W), .BLK_W(BLK_W)) u_data (
    .clk      (clk),
    .rstb     (rstb),
    .wr_en    (wr && data_sel && !is_busy),
    .wr_idx   (byte_idx),
    .wr_dat   (reg_data_o),
    .clr      (clr_ok),
    .mask_clr (done_ok),
    .rd_idx   (byte_idx),
    .rd_dat   (data_rd),
    .q        (aes_data),
    .mask     (data_mask),
    .full     (data_full)
  );

  // ---------------------------------------------------------- control FSM
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = BUSY;
      BUSY:    if (done_ok)  state_d = DONE;
      DONE: begin
        if (clr_ok)        state_d = IDLE;
        else if (start_ok) state_d = BUSY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    is_busy = 1'b0;
    is_done = 1'b0;
    unique case (state_q)
      BUSY:    is_busy = 1'b1;
      DONE:    is_done = 1'b1;
      default: ;
    endcase
  end

  // ------------------------------------------- ERR, RESULT, STATUS, START
  always_comb begin
    status_d           = '0;
    status_d[ST_BUSY]  = is_busy;
    status_d[ST_DONE]  = is_done;
    status_d[ST_ERR]   = err_q;
    status_d[ST_KFULL] = key_full;
    status_d[ST_DFULL] = data_full;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      err_q     <= 1'b0;
      result_q  <= '0;
      status    <= '0;
      aes_start <= 1'b0;
    end else begin
      // start_ok already carries ena, so the pulse is always one cycle wide.
      aes_start <= start_ok;
      if (ena) begin
        // A new error beats a simultaneous clear from CLR or a STATUS read.
        if (err_set) begin
          err_q <= 1'b1;
        end else if (clr_ok || stat_clr) begin
          err_q <= 1'b0;
        end
        if (clr_ok) begin
          result_q <= '0;
        end else if (done_ok) begin
          result_q <= aes_result;
        end
        status <= status_d;
      end
    end
  end

  // ------------------------------------------------------------ read mux
  always_comb begin
    reg_data_i = '0;
    if (key_sel) begin
      reg_data_i = key_rd;
    end else if (data_sel) begin
      reg_data_i = data_rd;
    end else if (res_sel) begin
      reg_data_i = result_q[(NBYTES-1-int'(byte_idx))*REG_W +: REG_W];
    end else if (stat_sel) begin
      reg_data_i = status;
    end
  end

  // Only the mask reductions are consumed; the vectors stay visible for debug.
  logic unused_masks;
  assign unused_masks = ^{key_mask, data_mask};

endmodule

// File: tb/tb_spi_aes_regbank.sv
// Directed bench for spi_aes_regbank with a queue-based scoreboard.
// Stimulus pushes expected read bytes / state snapshots; a monitor pops and
// compares whenever the DUT presents a read strobe or a snapshot is requested.
module tb_spi_aes_regbank;

  logic         clk = 1'b0;
  logic         rstb;
  logic         ena;
  logic [5:0]   reg_addr;
  logic         reg_rw;
  logic [7:0]   reg_data_o;
  logic         reg_data_o_dv;
  logic         reg_addr_v;
  logic [7:0]   reg_data_i;
  logic [7:0]   status;
  logic [127:0] aes_key;
  logic [127:0] aes_data;
  logic         aes_start;
  logic         aes_done;
  logic [127:0] aes_result;

  spi_aes_regbank dut (
    .clk           (clk),
    .rstb          (rstb),
    .ena           (ena),
    .reg_addr      (reg_addr),
    .reg_rw        (reg_rw),
    .reg_data_o    (reg_data_o),
    .reg_data_o_dv (reg_data_o_dv),
    .reg_addr_v    (reg_addr_v),
    .reg_data_i    (reg_data_i),
    .status        (status),
    .aes_key       (aes_key),
    .aes_data      (aes_data),
    .aes_start     (aes_start),
    .aes_done      (aes_done),
    .aes_result    (aes_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] a;
    logic [7:0] v;
  } rd_exp_t;

  typedef struct {
    logic [7:0]   s;
    logic [127:0] k;
    logic [127:0] d;
  } snap_exp_t;

  rd_exp_t   rdq[$];
  snap_exp_t snq[$];
  logic      snap = 1'b0;
  int        total = 0;
  int        bad = 0;
  int        start_cnt = 0;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] D15 = 128'h101112131415161718191a1b1c1d1e00;
  localparam logic [127:0] D1  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] D2  = 128'h202122232425262728292a2b2c2d2e2f;
  localparam logic [127:0] K3  = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
  localparam logic [127:0] D3  = 128'hb0b1b2b3b4b5b6b7b8b9babbbcbdbebf;
  localparam logic [127:0] RES = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from input changes.
  initial begin
    forever begin
      @(negedge clk);
      if (aes_start === 1'b1) start_cnt++;
      if (reg_addr_v) begin
        if (rdq.size() == 0) begin
          check("rd_unexpected", 128'(reg_addr), 128'h0);
        end else begin
          rd_exp_t e;
          e = rdq.pop_front();
          check($sformatf("rd@%02h", e.a), 128'(reg_data_i), 128'(e.v));
        end
      end
      if (snap) begin
        if (snq.size() == 0) begin
          check("snap_unexpected", 128'(status), 128'h0);
        end else begin
          snap_exp_t e;
          e = snq.pop_front();
          check("status", 128'(status), 128'(e.s));
          check("aes_key", aes_key, e.k);
          check("aes_data", aes_data, e.d);
        end
      end
    end
  end

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    reg_addr = a; reg_rw = 1'b1; reg_data_o = d; reg_data_o_dv = 1'b1;
    @(posedge clk); #1;
    reg_data_o_dv = 1'b0; reg_rw = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [7:0] exp);
    rd_exp_t e;
    @(posedge clk); #1;
    reg_addr = a; reg_rw = 1'b0; reg_addr_v = 1'b1;
    e.a = a; e.v = exp;
    rdq.push_back(e);
    @(posedge clk); #1;
    reg_addr_v = 1'b0;
  endtask

  // Lets STATUS settle (state update + one register stage) before sampling.
  task automatic snapshot(input logic [7:0] s, input logic [127:0] k, input logic [127:0] d);
    snap_exp_t e;
    repeat (2) @(posedge clk);
    #1;
    e.s = s; e.k = k; e.d = d;
    snq.push_back(e);
    snap = 1'b1;
    @(posedge clk); #1;
    snap = 1'b0;
  endtask

  // Result is only valid in the done cycle; it is scrambled afterwards.
  task automatic done_pulse(input logic [127:0] r);
    @(posedge clk); #1;
    aes_done = 1'b1; aes_result = r;
    @(posedge clk); #1;
    aes_done = 1'b0; aes_result = ~r;
  endtask

  initial begin
    rstb = 1'b0; ena = 1'b1; reg_addr = '0; reg_rw = 1'b0; reg_data_o = '0;
    reg_data_o_dv = 1'b0; reg_addr_v = 1'b0; aes_done = 1'b0; aes_result = '0;
    repeat (3) @(posedge clk);
    #1 rstb = 1'b1;

    // Reset state
    snapshot(8'h00, 128'h0, 128'h0);
    rd(6'h20, 8'h00);
    rd(6'h31, 8'h00);

    // Full key load
    for (int i = 0; i < 16; i++) wr(6'(i), 8'(i));
    snapshot(8'h08, K1, 128'h0);
    rd(6'h05, 8'h05);
    rd(6'h0F, 8'h0F);
    rd(6'h30, 8'h00);
    rd(6'h3F, 8'h00);

    // Partial data load then START -> refused, ERR; STATUS read clears ERR
    for (int i = 0; i < 15; i++) wr(6'(16 + i), 8'(16 + i));
    wr(6'h30, 8'h01);
    snapshot(8'h0C, K1, D15);
    check("start_cnt_refused", 128'(start_cnt), 128'd0);
    rd(6'h31, 8'h0C);
    snapshot(8'h08, K1, D15);

    // Complete data, START, completion
    wr(6'h1F, 8'h1F);
    snapshot(8'h18, K1, D1);
    wr(6'h30, 8'h01);
    snapshot(8'h19, K1, D1);
    check("start_cnt_first", 128'(start_cnt), 128'd1);
    done_pulse(RES);
    snapshot(8'h0A, K1, D1);
    rd(6'h20, 8'h69);
    rd(6'h27, 8'h30);
    rd(6'h2F, 8'h5A);
    rd(6'h13, 8'h13);

    // Reload data in DONE, restart, then illegal accesses while BUSY
    for (int i = 0; i < 16; i++) wr(6'(16 + i), 8'(32 + i));
    snapshot(8'h1A, K1, D2);
    wr(6'h30, 8'h01);
    snapshot(8'h19, K1, D2);
    check("start_cnt_second", 128'(start_cnt), 128'd2);
    wr(6'h03, 8'hFF);
    wr(6'h30, 8'h02);
    snapshot(8'h1D, K1, D2);
    rd(6'h03, 8'h03);
    rd(6'h20, 8'h69);

    // Reset mid-BUSY, then a stale completion from the core
    @(posedge clk); #1 rstb = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
    done_pulse(RES);
    snapshot(8'h00, 128'h0, 128'h0);
    rd(6'h20, 8'h00);
    rd(6'h2F, 8'h00);

    // Back to DONE, refused START sets ERR, then CTRL=0x03 clears everything
    for (int i = 0; i < 16; i++) wr(6'(i), 8'(160 + i));
    for (int i = 0; i < 16; i++) wr(6'(16 + i), 8'(176 + i));
    wr(6'h30, 8'h01);
    snapshot(8'h19, K3, D3);
    check("start_cnt_third", 128'(start_cnt), 128'd3);
    done_pulse(RES);
    snapshot(8'h0A, K3, D3);
    wr(6'h30, 8'h01);
    snapshot(8'h0E, K3, D3);
    wr(6'h30, 8'h03);
    snapshot(8'h00, 128'h0, 128'h0);
    check("start_cnt_clr", 128'(start_cnt), 128'd3);
    rd(6'h00, 8'h00);
    rd(6'h1F, 8'h00);
    rd(6'h20, 8'h00);

    // ena low freezes the bank
    ena = 1'b0;
    wr(6'h00, 8'hAA);
    ena = 1'b1;
    rd(6'h00, 8'h00);
    snapshot(8'h00, 128'h0, 128'h0);

    repeat (3) @(posedge clk);
    check("rdq_left", 128'(rdq.size()), 128'd0);
    check("snq_left", 128'(snq.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
